ide_cycle_sequencer: RTL and testbench

IDE_CYCLE_SEQUENCER -- requirements
Module: ide_cycle_sequencer

---
 rtl/ide_pkg.sv | 43 ++++
 rtl/sync_ff.sv | 23 ++
 rtl/ide_cycle_sequencer.sv | 151 +++++++++++++++
 tb/tb_ide_cycle_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ide_pkg.sv
// Shared definitions for the IDE PIO cycle sequencer: state encoding,
// per-mode timing table and the strobe timeout default.
package ide_pkg;

    localparam int CNT_W              = 7;
    localparam int TIMEOUT_CYCLES_DEF = 64;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_ACK     = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    typedef struct packed {
        cnt_t setup;
        cnt_t strobe;
        cnt_t recover;
    } pio_timing_t;

    // Cycle counts in CLK periods: setup / strobe / recover.
    localparam pio_timing_t PIO_MODE0 = '{setup: 7'd2, strobe: 7'd3, recover: 7'd3};
    localparam pio_timing_t PIO_MODE1 = '{setup: 7'd1, strobe: 7'd3, recover: 7'd2};
    localparam pio_timing_t PIO_MODE2 = '{setup: 7'd1, strobe: 7'd2, recover: 7'd1};
    localparam pio_timing_t PIO_MODE3 = '{setup: 7'd1, strobe: 7'd1, recover: 7'd1};

    function automatic pio_timing_t pio_timing(input logic [1:0] mode);
        pio_timing_t t;
        case (mode)
            2'd0:    t = PIO_MODE0;
            2'd1:    t = PIO_MODE1;
            2'd2:    t = PIO_MODE2;
            default: t = PIO_MODE3;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchroniser for a single asynchronous level input.
module sync_ff #(
    parameter int DEPTH = 2
) (
    input  logic CLK,
    input  logic RESET_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stage;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            stage <= '0;
        end else begin
            stage <= {stage[DEPTH-2:0], d};
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/ide_cycle_sequencer.sv
// Sequences one IDE PIO register access per 68k bus cycle: setup, strobe
// (stretched by IORDY, bounded by a timeout), DTACK, then recovery.
//
//   state   | meaning
//   IDLE    | waiting for a qualified request (AS_n low, ide_access high)
//   SETUP   | address setup, both strobes high
//   STROBE  | IOR_n or IOW_n low; min width, then stretched while IORDY low
//   ACK     | strobes high, DTACK high for this single cycle
//   RECOVER | recovery time, and waiting for AS_n to have gone high
module ide_cycle_sequencer
    import ide_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       CLK,
    input  logic       RESET_n,
    input  logic       AS_n,
    input  logic       RW,
    input  logic       ide_access,
    input  logic [1:0] pio_mode,
    input  logic       IORDY,
    output logic       IOR_n,
    output logic       IOW_n,
    output logic       DTACK,
    output logic       busy,
    output logic       timeout_err
);

    localparam int   SYNC_DEPTH = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam cnt_t TMO_LAST   = cnt_t'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    cnt_t        cnt;
    logic [1:0]  mode_lat;
    logic        rw_lat;
    pio_timing_t tim;
    logic        iordy_sync;
    logic        as_rel_q;
    logic        as_rel_now;
    logic        start_cycle;
    logic        setup_done;
    logic        strobe_min_done;
    logic        strobe_ready;
    logic        tmo_hit;
    logic        tmo_set;
    logic        rec_done;
    logic        ior_n_nxt;
    logic        iow_n_nxt;
    logic        dtack_nxt;
    logic        busy_nxt;

    sync_ff #(.DEPTH(SYNC_DEPTH)) u_iordy_sync (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .d       (IORDY),
        .q       (iordy_sync)
    );

    // as_rel tracks whether AS_n has been seen high since the cycle started,
    // so a new request pending during RECOVER cannot stall the exit.
    assign as_rel_now      = as_rel_q | AS_n;
    assign start_cycle     = (state == ST_IDLE) && ide_access && !AS_n && as_rel_q;
    assign tim             = pio_timing(mode_lat);
    assign setup_done      = cnt >= (tim.setup - 7'd1);
    assign strobe_min_done = cnt >= (tim.strobe - 7'd1);
    assign strobe_ready    = strobe_min_done && iordy_sync;
    assign tmo_hit         = cnt >= TMO_LAST;
    assign rec_done        = cnt >= (tim.recover - 7'd1);
    assign tmo_set         = (state == ST_STROBE) && !AS_n && !strobe_ready && tmo_hit;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state <= ST_IDLE;
            IOR_n <= 1'b1;
            IOW_n <= 1'b1;
            DTACK <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            IOR_n <= ior_n_nxt;
            IOW_n <= iow_n_nxt;
            DTACK <= dtack_nxt;
            busy  <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_cycle) state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                if (AS_n)            state_nxt = ST_RECOVER;
                else if (setup_done) state_nxt = ST_STROBE;
            end
            ST_STROBE: begin
                if (AS_n)              state_nxt = ST_RECOVER;
                else if (strobe_ready) state_nxt = ST_ACK;
                else if (tmo_hit)      state_nxt = ST_ACK;
            end
            ST_ACK: begin
                state_nxt = ST_RECOVER;
            end
            ST_RECOVER: begin
                if (rec_done && as_rel_now) state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the entry edge.
    always_comb begin
        ior_n_nxt = 1'b1;
        iow_n_nxt = 1'b1;
        dtack_nxt = 1'b0;
        busy_nxt  = (state_nxt != ST_IDLE);
        if (state_nxt == ST_STROBE) begin
            if (rw_lat) ior_n_nxt = 1'b0;
            else        iow_n_nxt = 1'b0;
        end
        if (state_nxt == ST_ACK) dtack_nxt = 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            cnt         <= '0;
            mode_lat    <= 2'd0;
            rw_lat      <= 1'b0;
            as_rel_q    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if ((state_nxt != state) || (state == ST_IDLE)) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 7'd1;
            end
            if (start_cycle) begin
                mode_lat <= pio_mode;
                rw_lat   <= RW;
            end
            as_rel_q <= start_cycle ? 1'b0 : as_rel_now;
            if (tmo_set) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ide_cycle_sequencer.sv
// Randomised bench for ide_cycle_sequencer; expected output traces come from
// per-transaction event times computed from the mode timing rules.
module tb_ide_cycle_sequencer;

    localparam int TO   = 64;
    localparam int SYNC = 2;
    localparam int SET_T [4] = '{2, 1, 1, 1};
    localparam int STR_T [4] = '{3, 3, 2, 1};
    localparam int REC_T [4] = '{3, 2, 1, 1};

    logic       CLK;
    logic       RESET_n;
    logic       AS_n;
    logic       RW;
    logic       ide_access;
    logic [1:0] pio_mode;
    logic       IORDY;
    logic       IOR_n;
    logic       IOW_n;
    logic       DTACK;
    logic       busy;
    logic       timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    bit sticky   = 0;
    bit pend     = 0;

    ide_cycle_sequencer #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(SYNC)) dut (
        .CLK         (CLK),
        .RESET_n     (RESET_n),
        .AS_n        (AS_n),
        .RW          (RW),
        .ide_access  (ide_access),
        .pio_mode    (pio_mode),
        .IORDY       (IORDY),
        .IOR_n       (IOR_n),
        .IOW_n       (IOW_n),
        .DTACK       (DTACK),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial CLK = 1'b0;
    always #70 CLK = ~CLK;

    initial begin
        #8_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic bit iordy_at(input int e, input int ls, input int le);
        return !(e >= ls && e < le);
    endfunction

    // Strobe length: at least the mode minimum, then until IORDY (seen SYNC
    // edges late) is high, capped at TO cycles which counts as a timeout.
    function automatic int strobe_len(input int s, input int t, input int ls, input int le,
                                      output bit tmo);
        tmo = 1'b1;
        for (int k = t - 1; k < TO; k++) begin
            if (iordy_at(s + k + 1 - SYNC, ls, le)) begin
                tmo = 1'b0;
                return k + 1;
            end
        end
        return TO;
    endfunction

    // Edge 0 is the first edge sampling the request. abort_pick: -1 none,
    // 0 random edge inside SETUP/STROBE, >0 that edge. AS_n high at edge r.
    task automatic run_txn(input string tag, input int mode, input bit rw,
                           input int ls, input int le, input int abort_pick,
                           input int rel_delay, input bit pend_next);
        int s, t, rc, l, a, r, e0, x, lact;
        bit tmo, aborted, tmo_now;
        logic [4:0] expv;
        s  = SET_T[mode];
        t  = STR_T[mode];
        rc = REC_T[mode];
        l  = strobe_len(s, t, ls, le, tmo);
        aborted = (abort_pick >= 0);
        if (aborted) begin
            a    = (abort_pick == 0) ? int'($urandom_range(s + l, 1)) : abort_pick;
            r    = a;
            e0   = a;
            lact = (a - s < l) ? a - s : l;
            if (lact < 0) lact = 0;
        end else begin
            e0   = s + l + 1;
            r    = e0 + rel_delay;
            lact = l;
        end
        x = (e0 + rc > r) ? e0 + rc : r;
        tmo_now = tmo && !aborted;

        AS_n       = 1'b0;
        ide_access = 1'b1;
        RW         = rw;
        pio_mode   = 2'(mode);
        IORDY      = iordy_at(0, ls, le);
        for (int e = 0; e <= x; e++) begin
            @(posedge CLK);
            @(negedge CLK);
            expv[4] = (e < x);
            expv[3] = !(rw && e >= s && e < s + lact);
            expv[2] = !(!rw && e >= s && e < s + lact);
            expv[1] = !aborted && (e == s + l);
            expv[0] = sticky || (tmo_now && e >= s + l);
            check_val(tag, {busy, IOR_n, IOW_n, DTACK, timeout_err}, expv);
            IORDY    = iordy_at(e + 1, ls, le);
            AS_n     = (e + 1 < r) ? 1'b0 : ((e + 1 == r) ? 1'b1 : !pend_next);
            pio_mode = 2'($urandom);
            RW       = 1'($urandom);
        end
        IORDY = 1'b1;
        if (!pend_next) ide_access = 1'b0;
        sticky = sticky || tmo_now;
        pend   = pend_next;
    endtask

    // as_mode: 0 AS_n high, 1 random, 2 low; ide_access is held off.
    task automatic idle_gap(input int n, input int as_mode);
        for (int g = 0; g < n; g++) begin
            AS_n       = (as_mode == 0) ? 1'b1 : ((as_mode == 2) ? 1'b0 : 1'($urandom));
            ide_access = 1'b0;
            IORDY      = 1'($urandom);
            RW         = 1'($urandom);
            pio_mode   = 2'($urandom);
            @(posedge CLK);
            @(negedge CLK);
            check_val("idle", {busy, IOR_n, IOW_n, DTACK, timeout_err},
                      {1'b0, 1'b1, 1'b1, 1'b0, sticky});
        end
        pend = 0;
    endtask

    initial begin
        int mode, ls, le, ab, sel;
        RESET_n    = 1'b0;
        AS_n       = 1'b1;
        RW         = 1'b0;
        ide_access = 1'b0;
        pio_mode   = 2'd0;
        IORDY      = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check_val("reset", {busy, IOR_n, IOW_n, DTACK, timeout_err}, 5'b01100);
        end
        RESET_n = 1'b1;
        idle_gap(2, 0);

        run_txn("m0_read",      0, 1'b1, 0, 0,    -1, 0, 1'b0);
        idle_gap(2, 2);
        run_txn("m3_write",     3, 1'b0, 0, 0,    -1, 1, 1'b0);
        idle_gap(1, 0);
        run_txn("m2_iordy_ext", 2, 1'b1, 1, 11,   -1, 0, 1'b0);
        idle_gap(1, 0);
        run_txn("timeout",      0, 1'b1, 0, 1000, -1, 2, 1'b0);
        idle_gap(1, 0);
        run_txn("abort_strobe", 1, 1'b1, 0, 0,     2, 0, 1'b1);
        run_txn("after_abort",  0, 1'b0, 0, 0,    -1, 0, 1'b0);
        idle_gap(1, 0);
        run_txn("abort_setup",  0, 1'b0, 0, 0,     1, 0, 1'b1);
        run_txn("pend_m1",      1, 1'b1, 0, 0,    -1, 1, 1'b1);
        run_txn("pend_m2",      2, 1'b0, 0, 0,    -1, 0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            if (!pend) idle_gap($urandom_range(3, 0), 1);
            mode = $urandom_range(3, 0);
            sel  = $urandom_range(15, 0);
            if (sel == 0) begin
                ls = 0;
                le = 1000;
            end else if (sel < 8) begin
                ls = $urandom_range(SET_T[mode] + 4, 0);
                le = ls + $urandom_range(20, 1);
            end else begin
                ls = 0;
                le = 0;
            end
            ab = ($urandom_range(4, 0) == 0) ? 0 : -1;
            run_txn("rand", mode, 1'($urandom), ls, le, ab,
                    $urandom_range(REC_T[mode] + 2, 0), $urandom_range(2, 0) == 0);
        end
        if (!pend) idle_gap(1, 0);

        AS_n       = 1'b0;
        ide_access = 1'b1;
        RW         = 1'b1;
        pio_mode   = 2'd0;
        IORDY      = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_val("rst_pre_strobe", {IOR_n, timeout_err}, {1'b0, sticky});
        #5 RESET_n = 1'b0;
        #1 check_val("rst_async", {busy, IOR_n, IOW_n, DTACK, timeout_err}, 5'b01100);
        sticky = 0;
        repeat (2) begin
            @(negedge CLK);
            check_val("rst_hold", {busy, IOR_n, IOW_n, DTACK, timeout_err}, 5'b01100);
        end
        RESET_n = 1'b1;
        IORDY   = 1'b1;
        repeat (4) begin
            @(posedge CLK);
            @(negedge CLK);
            check_val("no_fresh_as", {busy, IOR_n, IOW_n, DTACK, timeout_err}, 5'b01100);
        end
        idle_gap(1, 0);
        run_txn("post_reset", 1, 1'b0, 0, 0, -1, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
